// File: rtl/threshold_monitor.sv
// Periodic sensor-sampling controller.
// Every ParamPeriod_i+1 idle cycles it requests a sensor conversion, forms
// |new sample - last reported value| and hands threshold/difference to an
// external unsigned less-than comparator. When threshold < difference the new
// sample becomes the reported value and a one-cycle CPU interrupt is raised.
//
// Ports:
//   Clk_i, Reset_i        clock (rising edge), asynchronous active-high reset
//   Enable_i              1 = run, 0 = return to Disabled
//   ParamPeriod_i         idle cycles between measurements (loaded into timer)
//   ParamThreshold_i      notification threshold (captured in Diff)
//   MeasureStart_o        one-cycle conversion request (first Xfer cycle)
//   MeasureDone_i         conversion complete, SensorValue_i valid
//   SensorValue_i         sensor sample
//   CmpA_o, CmpB_o        comparator operands (threshold, absolute difference)
//   CmpLess_i             comparator result, CmpA_o < CmpB_o
//   CpuIntr_o             one-cycle interrupt pulse
//   LastValue_o           last reported sample
module threshold_monitor #(
  parameter int unsigned Width      = 16,
  parameter int unsigned TimerWidth = 16
) (
  input  logic                  Clk_i,
  input  logic                  Reset_i,
  input  logic                  Enable_i,
  input  logic [TimerWidth-1:0] ParamPeriod_i,
  input  logic [Width-1:0]      ParamThreshold_i,
  output logic                  MeasureStart_o,
  input  logic                  MeasureDone_i,
  input  logic [Width-1:0]      SensorValue_i,
  output logic [Width-1:0]      CmpA_o,
  output logic [Width-1:0]      CmpB_o,
  input  logic                  CmpLess_i,
  output logic                  CpuIntr_o,
  output logic [Width-1:0]      LastValue_o
);

  typedef enum logic [2:0] {
    StDisabled,
    StIdle,
    StXfer,
    StDiff,
    StCompare
  } state_e;

  state_e                state_q;
  logic [TimerWidth-1:0] timer_q;
  logic [Width-1:0]      new_value_q;
  logic [Width-1:0]      last_value_q;
  logic [Width-1:0]      cmp_a_q;
  logic [Width-1:0]      cmp_b_q;
  logic                  measure_start_q;
  logic                  cpu_intr_q;

  // Width+1-bit subtraction: the borrow bit tells which operand is larger.
  logic [Width:0]   diff_raw;
  logic [Width-1:0] abs_diff;

  assign diff_raw = {1'b0, new_value_q} - {1'b0, last_value_q};
  assign abs_diff = diff_raw[Width] ? (last_value_q - new_value_q) : diff_raw[Width-1:0];

  always_ff @(posedge Clk_i or posedge Reset_i) begin
    if (Reset_i) begin
      state_q         <= StDisabled;
      timer_q         <= '0;
      new_value_q     <= '0;
      last_value_q    <= '0;
      cmp_a_q         <= '0;
      cmp_b_q         <= '0;
      measure_start_q <= 1'b0;
      cpu_intr_q      <= 1'b0;
    end else begin
      // Both strobes are single-cycle; any pulse already registered still
      // shows for its one cycle even if Enable_i drops.
      measure_start_q <= 1'b0;
      cpu_intr_q      <= 1'b0;
      if (!Enable_i) begin
        // Abandon any in-flight measurement; reported value and operands stay.
        state_q <= StDisabled;
      end else begin
        unique case (state_q)
          StDisabled: begin
            state_q <= StIdle;
            timer_q <= ParamPeriod_i;
          end
          StIdle: begin
            if (timer_q == '0) begin
              state_q         <= StXfer;
              measure_start_q <= 1'b1;
            end else begin
              timer_q <= timer_q - TimerWidth'(1);
            end
          end
          StXfer: begin
            if (MeasureDone_i) begin
              new_value_q <= SensorValue_i;
              state_q     <= StDiff;
            end
          end
          StDiff: begin
            cmp_a_q <= ParamThreshold_i;
            cmp_b_q <= abs_diff;
            state_q <= StCompare;
          end
          StCompare: begin
            if (CmpLess_i) begin
              last_value_q <= new_value_q;
              cpu_intr_q   <= 1'b1;
            end
            state_q <= StIdle;
            timer_q <= ParamPeriod_i;
          end
          default: state_q <= StDisabled;
        endcase
      end
    end
  end

  assign MeasureStart_o = measure_start_q;
  assign CpuIntr_o      = cpu_intr_q;
  assign CmpA_o         = cmp_a_q;
  assign CmpB_o         = cmp_b_q;
  assign LastValue_o    = last_value_q;

endmodule

// File: tb/tb_threshold_monitor.sv
module tb_threshold_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] period;
  logic [15:0] threshold;
  logic        measure_start;
  logic        measure_done;
  logic [15:0] sensor_value;
  logic [15:0] cmp_a;
  logic [15:0] cmp_b;
  logic        cmp_less;
  logic        cpu_intr;
  logic [15:0] last_value;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 clk = ~clk;

  // External comparator cell: purely combinational.
  assign cmp_less = (cmp_a < cmp_b);

  threshold_monitor #(
    .Width      (16),
    .TimerWidth (16)
  ) dut (
    .Clk_i            (clk),
    .Reset_i          (rst),
    .Enable_i         (enable),
    .ParamPeriod_i    (period),
    .ParamThreshold_i (threshold),
    .MeasureStart_o   (measure_start),
    .MeasureDone_i    (measure_done),
    .SensorValue_i    (sensor_value),
    .CmpA_o           (cmp_a),
    .CmpB_o           (cmp_b),
    .CmpLess_i        (cmp_less),
    .CpuIntr_o        (cpu_intr),
    .LastValue_o      (last_value)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  // Waits (bounded) for the conversion request; returns negedges waited.
  task automatic wait_start(input int budget, output int cycles);
    cycles = 0;
    while (measure_start !== 1'b1 && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  // One measurement with zero sensor latency, Done given in the first Xfer
  // cycle (cycle k). Operands visible in k+2, interrupt/last value in k+3.
  task automatic measure(input string tag, input logic [15:0] thr, input logic [15:0] sample,
                         input logic [15:0] exp_diff, input logic exp_intr,
                         input logic [15:0] exp_last);
    int w;
    threshold = thr;
    wait_start(40, w);
    check({tag, "_start"}, measure_start, 1'b1);
    measure_done = 1'b1;
    sensor_value = sample;
    step(1);
    measure_done = 1'b0;
    check({tag, "_start_width"}, measure_start, 1'b0);
    step(1);
    check({tag, "_cmp_a"}, cmp_a, thr);
    check({tag, "_cmp_b"}, cmp_b, exp_diff);
    step(1);
    check({tag, "_intr"}, cpu_intr, exp_intr);
    check({tag, "_last"}, last_value, exp_last);
    step(1);
    check({tag, "_intr_off"}, cpu_intr, 1'b0);
  endtask

  initial begin
    rst          = 1'b1;
    enable       = 1'b0;
    period       = 16'd3;
    threshold    = 16'd100;
    measure_done = 1'b0;
    sensor_value = 16'd0;
    step(2);
    check("rst_start", measure_start, 1'b0);
    check("rst_intr", cpu_intr, 1'b0);
    check("rst_last", last_value, 16'd0);
    check("rst_cmp_a", cmp_a, 16'd0);
    check("rst_cmp_b", cmp_b, 16'd0);

    // Period 3: Disabled->Idle on first edge, four Idle cycles, then Xfer.
    rst    = 1'b0;
    enable = 1'b1;
    wait_start(40, n);
    check("first_period", n, 5);

    // Basic notify / no-notify.
    measure("t150", 16'd100, 16'd150, 16'd150, 1'b1, 16'd150);
    measure("t200", 16'd100, 16'd200, 16'd50, 1'b0, 16'd150);

    // Boundary around equality, new < old path.
    measure("t500", 16'd100, 16'd500, 16'd350, 1'b1, 16'd500);
    measure("t480", 16'd20, 16'd480, 16'd20, 1'b0, 16'd500);
    measure("t479", 16'd20, 16'd479, 16'd21, 1'b1, 16'd479);

    // Extremes.
    measure("z0a", 16'd0, 16'd0, 16'd479, 1'b1, 16'd0);
    measure("max_hit", 16'hFFFE, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF);
    measure("z0b", 16'd0, 16'd0, 16'hFFFF, 1'b1, 16'd0);
    measure("max_miss", 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, 16'd0);

    // Drop Enable_i in Xfer; a late Done must be ignored.
    wait_start(40, n);
    check("dis_start", measure_start, 1'b1);
    enable = 1'b0;
    step(1);
    measure_done = 1'b1;
    sensor_value = 16'd1234;
    threshold    = 16'd0;
    step(1);
    measure_done = 1'b0;
    check("dis_intr0", cpu_intr, 1'b0);
    step(1);
    check("dis_intr1", cpu_intr, 1'b0);
    step(1);
    check("dis_intr2", cpu_intr, 1'b0);
    check("dis_last", last_value, 16'd0);
    check("dis_cmp_a", cmp_a, 16'hFFFF);
    check("dis_cmp_b", cmp_b, 16'hFFFF);
    check("dis_start_off", measure_start, 1'b0);

    // Re-enable: fresh full period.
    period = 16'd3;
    enable = 1'b1;
    wait_start(40, n);
    check("reen_period", n, 5);

    // Period 0, Done coincident with MeasureStart_o.
    period       = 16'd0;
    threshold    = 16'd0;
    measure_done = 1'b1;
    sensor_value = 16'h0010;
    step(1);
    measure_done = 1'b0;
    check("p0_diff_start", measure_start, 1'b0);
    step(1);
    check("p0_cmp_b", cmp_b, 16'h0010);
    check("p0_intr_k2", cpu_intr, 1'b0);
    step(1);
    check("p0_intr_k3", cpu_intr, 1'b1);
    check("p0_last", last_value, 16'h0010);
    check("p0_start_k3", measure_start, 1'b0);
    step(1);
    check("p0_start_k4", measure_start, 1'b1);
    check("p0_intr_k4", cpu_intr, 1'b0);

    // Asynchronous reset in the middle of an Xfer cycle.
    #2 rst = 1'b1;
    #1;
    check("arst_start", measure_start, 1'b0);
    check("arst_intr", cpu_intr, 1'b0);
    check("arst_last", last_value, 16'd0);
    check("arst_cmp_a", cmp_a, 16'd0);
    check("arst_cmp_b", cmp_b, 16'd0);
    step(1);
    rst = 1'b0;
    step(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
